// File: rtl/pref_refresh_queue_if.sv
// rtl/pref_refresh_queue_if.sv - tracker request, refresh command and status bundle for pref_refresh_queue
interface pref_refresh_queue_if #(
  parameter int ROW_ADDR_BIT = 16,
  parameter int BANK_ID_W    = 4,
  parameter int QUEUE_DEPTH  = 8
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic                    req_i;
  logic [BANK_ID_W-1:0]    bank_id_i;
  logic [ROW_ADDR_BIT-1:0] victim_low_i;
  logic [ROW_ADDR_BIT-1:0] victim_high_i;
  logic                    pref_valid_o;
  logic                    pref_ready_i;
  logic [BANK_ID_W-1:0]    pref_bank_o;
  logic [ROW_ADDR_BIT-1:0] pref_row_o;
  logic [CW-1:0]           count_o;
  logic                    overflow_o;
  logic [7:0]              drop_cnt_o;

  modport slave (
    input  req_i, bank_id_i, victim_low_i, victim_high_i, pref_ready_i,
    output pref_valid_o, pref_bank_o, pref_row_o, count_o, overflow_o, drop_cnt_o
  );

  modport master (
    output req_i, bank_id_i, victim_low_i, victim_high_i, pref_ready_i,
    input  pref_valid_o, pref_bank_o, pref_row_o, count_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/pref_refresh_queue.sv
// rtl/pref_refresh_queue.sv - preventive-refresh request FIFO draining as single-row refresh commands
// Define PREF_DEDUP_EN to silently discard requests already present in the queue.
module pref_refresh_queue #(
  parameter int ROW_ADDR_BIT = 16,
  parameter int BANK_ID_W    = 4,
  parameter int QUEUE_DEPTH  = 8,
  parameter int GAP_CYCLES   = 4
) (
  input logic                 clk_i,
  input logic                 rst_i,
  pref_refresh_queue_if.slave bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE_LOW, ISSUE_HIGH, GAP} state_t;
  state_t state, state_d;

  logic [BANK_ID_W-1:0]    bank_mem [QUEUE_DEPTH];
  logic [ROW_ADDR_BIT-1:0] low_mem  [QUEUE_DEPTH];
  logic [ROW_ADDR_BIT-1:0] high_mem [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]  dual_mem;

  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    valid_q, valid_d;
  logic [ROW_ADDR_BIT-1:0] row_q, row_d;
  logic [BANK_ID_W-1:0]    bank_q, bank_d;
  logic [GW-1:0]           gap_cnt, gap_d;
  logic                    overflow_q;
  logic [7:0]              drop_cnt_q;
  logic                    handshake, pop, dup, push, drop;

  // valid_q is high exactly in the two ISSUE states, so it doubles as the state qualifier
  assign handshake = valid_q & bus.pref_ready_i;
  assign pop = handshake & ((state == ISSUE_HIGH) | ((state == ISSUE_LOW) & ~dual_mem[rd_ptr]));

`ifdef PREF_DEDUP_EN
  logic [AW-1:0] dup_slot;
  // The head stays matchable until its pop cycle; a same-cycle duplicate of a popping head is new
  always_comb begin
    dup      = 1'b0;
    dup_slot = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if ((CW'(i) < count) && !((i == 0) && pop)) begin
        dup_slot = rd_ptr + AW'(i);
        if ((bank_mem[dup_slot] == bus.bank_id_i) &&
            (low_mem[dup_slot] == bus.victim_low_i) &&
            (high_mem[dup_slot] == bus.victim_high_i))
          dup = 1'b1;
      end
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign push = bus.req_i & ~dup & ((count != FULL) | pop);
  assign drop = bus.req_i & ~dup & (count == FULL) & ~pop;

  always_comb begin
    state_d = state;
    valid_d = valid_q;
    row_d   = row_q;
    bank_d  = bank_q;
    gap_d   = gap_cnt;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_d = ISSUE_LOW;
          valid_d = 1'b1;
          row_d   = low_mem[rd_ptr];
          bank_d  = bank_mem[rd_ptr];
        end
      end
      ISSUE_LOW: begin
        if (handshake) begin
          if (dual_mem[rd_ptr]) begin
            state_d = ISSUE_HIGH;
            row_d   = high_mem[rd_ptr];
          end else begin
            valid_d = 1'b0;
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      ISSUE_HIGH: begin
        if (handshake) begin
          valid_d = 1'b0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          gap_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d = IDLE;
        else               gap_d   = gap_cnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      row_q   <= '0;
      bank_q  <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      bank_q  <= bank_d;
      gap_cnt <= gap_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      bank_mem[wr_ptr] <= bus.bank_id_i;
      low_mem[wr_ptr]  <= bus.victim_low_i;
      high_mem[wr_ptr] <= bus.victim_high_i;
      dual_mem[wr_ptr] <= (bus.victim_low_i != bus.victim_high_i);
    end
  end

  assign bus.pref_valid_o = valid_q;
  assign bus.pref_row_o   = row_q;
  assign bus.pref_bank_o  = bank_q;
  assign bus.count_o      = count;
  assign bus.overflow_o   = overflow_q;
  assign bus.drop_cnt_o   = drop_cnt_q;
endmodule

// File: tb/tb_pref_refresh_queue.sv
// tb/tb_pref_refresh_queue.sv - self-checking bench for pref_refresh_queue against a queue-level model
module tb_pref_refresh_queue;
  localparam int RW  = 16;
  localparam int BW  = 4;
  localparam int QD  = 8;
  localparam int GAP = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  pref_refresh_queue_if #(.ROW_ADDR_BIT(RW), .BANK_ID_W(BW), .QUEUE_DEPTH(QD)) dif ();

  pref_refresh_queue #(.ROW_ADDR_BIT(RW), .BANK_ID_W(BW), .QUEUE_DEPTH(QD), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (dif)
  );

  typedef struct {
    logic [BW-1:0] bank;
    logic [RW-1:0] low;
    logic [RW-1:0] high;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // Model: queued requests, whether the head's low row went out, and the forced-idle countdown
  ent_t          mq[$];
  bit            m_issued_low = 0;
  bit            m_valid = 0;
  int            m_wait = 0;
  bit            m_ovf = 0;
  int            m_drops = 0;
  logic [RW-1:0] m_row = '0;
  logic [BW-1:0] m_bank = '0;

  logic          obs_valid, obs_ovf, obs_hs;
  logic [RW-1:0] obs_row;
  logic [BW-1:0] obs_bank;
  logic [3:0]    obs_count;
  logic [7:0]    obs_drops;
  logic          exp_valid, exp_ovf;
  logic [RW-1:0] exp_row;
  logic [BW-1:0] exp_bank;
  logic [3:0]    exp_count;
  logic [7:0]    exp_drops;

  task automatic step(input bit rst, input bit req, input logic [BW-1:0] b,
                      input logic [RW-1:0] lo, input logic [RW-1:0] hi, input bit rdy);
    bit pop, dup, do_push;
    int sz;
    ent_t e;
    rst_i = rst;
    dif.req_i = req;
    dif.bank_id_i = b;
    dif.victim_low_i = lo;
    dif.victim_high_i = hi;
    dif.pref_ready_i = rdy;
    @(negedge clk_i);
    obs_valid = dif.pref_valid_o;
    obs_row   = dif.pref_row_o;
    obs_bank  = dif.pref_bank_o;
    obs_count = dif.count_o;
    obs_ovf   = dif.overflow_o;
    obs_drops = dif.drop_cnt_o;
    obs_hs    = obs_valid && rdy;
    exp_valid = m_valid;
    exp_row   = m_row;
    exp_bank  = m_bank;
    exp_count = 4'(mq.size());
    exp_ovf   = m_ovf;
    exp_drops = 8'(m_drops);
    if (rst) begin
      mq.delete();
      m_issued_low = 0; m_valid = 0; m_wait = 0; m_ovf = 0; m_drops = 0;
      m_row = '0; m_bank = '0;
    end else begin
      pop = 0; dup = 0; do_push = 0;
      sz = mq.size();
      if (m_valid && rdy) begin
        if (!m_issued_low && (mq[0].low != mq[0].high)) begin
          m_issued_low = 1;
          m_row = mq[0].high;
        end else begin
          pop = 1;
        end
      end else if (!m_valid) begin
        if (m_wait > 0) m_wait--;
        else if (sz > 0) begin
          m_valid = 1;
          m_row = mq[0].low;
          m_bank = mq[0].bank;
        end
      end
      if (req) begin
`ifdef PREF_DEDUP_EN
        for (int i = (pop ? 1 : 0); i < sz; i++)
          if (mq[i].bank == b && mq[i].low == lo && mq[i].high == hi) dup = 1;
`endif
        if (!dup) begin
          if (sz == QD && !pop) begin
            m_ovf = 1;
            m_drops = (m_drops < 255) ? m_drops + 1 : 255;
          end else begin
            do_push = 1;
          end
        end
      end
      if (pop) begin
        void'(mq.pop_front());
        m_issued_low = 0;
        m_valid = 0;
        m_wait = GAP;
      end
      if (do_push) begin
        e.bank = b; e.low = lo; e.high = hi;
        mq.push_back(e);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, '0, '0, '0, rdy);
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (mq.size() == 0 && !m_valid && m_wait == 0) begin
        ok = 1;
        break;
      end
      idle(1);
    end
  endtask

  task automatic test_reset();
    step(1, 0, '0, '0, '0, 0);
    step(1, 0, '0, '0, '0, 0);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", obs_valid); end
    checks++; if (obs_row !== 16'h0) begin errors++; $display("FAIL reset_row got %h want 0", obs_row); end
    checks++; if (obs_bank !== 4'h0) begin errors++; $display("FAIL reset_bank got %h want 0", obs_bank); end
    checks++; if (obs_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", obs_count); end
    checks++; if (obs_ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", obs_ovf); end
    checks++; if (obs_drops !== 8'd0) begin errors++; $display("FAIL reset_drops got %0d want 0", obs_drops); end
  endtask

  task automatic test_single();
    int first = -1;
    logic [RW-1:0] rows[$];
    logic [BW-1:0] banks[$];
    step(0, 1, 4'd3, 16'h0010, 16'h0012, 1);
    for (int cyc = 1; cyc < 12; cyc++) begin
      idle(1);
      checks++;
      if (obs_valid !== exp_valid || obs_row !== exp_row || obs_bank !== exp_bank) begin
        errors++;
        $display("FAIL single_model cyc %0d got v%0b r%h b%h want v%0b r%h b%h",
                 cyc, obs_valid, obs_row, obs_bank, exp_valid, exp_row, exp_bank);
      end
      if (obs_valid === 1'b1) begin
        if (first < 0) first = cyc;
        rows.push_back(obs_row);
        banks.push_back(obs_bank);
      end
    end
    checks++; if (first != 2) begin errors++; $display("FAIL single_latency got %0d want 2", first); end
    checks++;
    if (rows.size() != 2 || rows[0] !== 16'h0010 || rows[1] !== 16'h0012 || banks[0] !== 4'd3 || banks[1] !== 4'd3) begin
      errors++;
      $display("FAIL single_cmds got %0d commands want rows 0010,0012 bank 3", rows.size());
    end
    checks++; if (obs_count !== 4'd0) begin errors++; $display("FAIL single_count got %0d want 0", obs_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    step(0, 1, 4'd3, 16'h0010, 16'h0012, 0);
    for (int i = 0; i < 10 && obs_valid !== 1'b1; i++) idle(0);
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL bp_wait_valid got %0b want 1", obs_valid); end
    for (int k = 0; k < 5; k++) begin
      idle(0);
      checks++;
      if (obs_valid !== 1'b1 || obs_row !== 16'h0010 || obs_bank !== 4'd3) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v%0b r%h b%h want v1 r0010 b3", k, obs_valid, obs_row, obs_bank);
      end
    end
    idle(1);
    checks++; if (obs_row !== 16'h0010) begin errors++; $display("FAIL bp_low got %h want 0010", obs_row); end
    idle(1);
    checks++;
    if (obs_valid !== 1'b1 || obs_row !== 16'h0012) begin
      errors++; $display("FAIL bp_high got v%0b r%h want v1 r0012", obs_valid, obs_row);
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain got timeout want empty"); end
  endtask

  task automatic test_equal();
    int ncmd = 0;
    bit ok;
    step(0, 1, 4'd7, 16'h00FF, 16'h00FF, 1);
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (obs_valid === 1'b1) begin
        ncmd++;
        checks++;
        if (obs_row !== 16'h00FF || obs_bank !== 4'd7) begin
          errors++; $display("FAIL equal_row got r%h b%h want r00ff b7", obs_row, obs_bank);
        end
      end
    end
    checks++; if (ncmd != 1) begin errors++; $display("FAIL equal_count got %0d want 1", ncmd); end
    drain(ok);
  endtask

  task automatic test_overflow();
    ent_t ents[$];
    ent_t e;
    logic [RW-1:0] exp_rows[$];
    logic [BW-1:0] exp_banks[$];
    int idx = 0;
    step(1, 0, '0, '0, '0, 0);
    for (int i = 0; i < 10; i++) begin
      e.bank = 4'(i);
      e.low  = 16'(16'h0100 + 16'(i) * 16'd4);
      e.high = (i == 5) ? e.low : 16'(e.low + 16'd2);
      ents.push_back(e);
      step(0, 1, e.bank, e.low, e.high, 0);
    end
    idle(0);
    checks++; if (obs_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", obs_count); end
    checks++; if (obs_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", obs_ovf); end
    checks++; if (obs_drops !== 8'd2) begin errors++; $display("FAIL ovf_drops got %0d want 2", obs_drops); end
    for (int i = 0; i < 8; i++) begin
      exp_rows.push_back(ents[i].low); exp_banks.push_back(ents[i].bank);
      if (ents[i].low != ents[i].high) begin
        exp_rows.push_back(ents[i].high); exp_banks.push_back(ents[i].bank);
      end
    end
    for (int c = 0; c < 120; c++) begin
      idle(1);
      if (obs_hs === 1'b1) begin
        checks++;
        if (idx >= exp_rows.size() || obs_row !== exp_rows[idx] || obs_bank !== exp_banks[idx]) begin
          errors++; $display("FAIL ovf_order cmd %0d got r%h b%h", idx, obs_row, obs_bank);
        end
        idx++;
      end
    end
    checks++; if (idx != exp_rows.size()) begin errors++; $display("FAIL ovf_ncmd got %0d want %0d", idx, exp_rows.size()); end
    checks++; if (obs_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", obs_ovf); end
  endtask

  task automatic test_full_push_pop();
    ent_t ents[$];
    ent_t e;
    int nhs = 0;
    logic [RW-1:0] last_row = '0;
    logic [BW-1:0] last_bank = '0;
    step(1, 0, '0, '0, '0, 0);
    for (int i = 0; i < 8; i++) begin
      e.bank = 4'(i + 2); e.low = 16'(16'h2000 + 16'(i) * 16'd8); e.high = 16'(e.low + 16'd2);
      ents.push_back(e);
      step(0, 1, e.bank, e.low, e.high, 0);
    end
    for (int i = 0; i < 10 && obs_valid !== 1'b1; i++) idle(0);
    idle(1);
    checks++; if (obs_row !== ents[0].low) begin errors++; $display("FAIL fpp_low got %h want %h", obs_row, ents[0].low); end
    step(0, 1, 4'hE, 16'h7770, 16'h7772, 1);
    checks++; if (obs_row !== ents[0].high) begin errors++; $display("FAIL fpp_high got %h want %h", obs_row, ents[0].high); end
    idle(0);
    checks++; if (obs_count !== 4'd8) begin errors++; $display("FAIL fpp_count got %0d want 8", obs_count); end
    checks++; if (obs_drops !== 8'd0 || obs_ovf !== 1'b0) begin
      errors++; $display("FAIL fpp_nodrop got drops %0d ovf %0b want 0 0", obs_drops, obs_ovf);
    end
    for (int c = 0; c < 150; c++) begin
      idle(1);
      if (obs_hs === 1'b1) begin nhs++; last_row = obs_row; last_bank = obs_bank; end
    end
    checks++; if (nhs != 16) begin errors++; $display("FAIL fpp_ncmd got %0d want 16", nhs); end
    checks++; if (last_row !== 16'h7772 || last_bank !== 4'hE) begin
      errors++; $display("FAIL fpp_tail got r%h b%h want r7772 be", last_row, last_bank);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, '0, '0, '0, 0);
    step(0, 1, 4'd5, 16'h0300, 16'h0302, 0);
    step(0, 1, 4'd6, 16'h0400, 16'h0402, 0);
    for (int i = 0; i < 10 && obs_valid !== 1'b1; i++) idle(0);
    idle(1);
    step(1, 0, '0, '0, '0, 1);
    checks++; if (obs_valid !== 1'b1 || obs_row !== 16'h0302) begin
      errors++; $display("FAIL rstmid_in_high got v%0b r%h want v1 r0302", obs_valid, obs_row);
    end
    idle(1);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", obs_valid); end
    checks++; if (obs_count !== 4'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", obs_count); end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet cyc %0d got %0b want 0", i, obs_valid); end
    end
  endtask

  task automatic test_dedup();
    logic [3:0] want;
`ifdef PREF_DEDUP_EN
    want = 4'd1;
`else
    want = 4'd2;
`endif
    step(1, 0, '0, '0, '0, 0);
    step(0, 1, 4'd9, 16'h0500, 16'h0502, 0);
    step(0, 1, 4'd9, 16'h0500, 16'h0502, 0);
    idle(0);
    checks++; if (obs_count !== want) begin errors++; $display("FAIL dedup_count got %0d want %0d", obs_count, want); end
    checks++; if (obs_drops !== 8'd0) begin errors++; $display("FAIL dedup_drops got %0d want 0", obs_drops); end
  endtask

  task automatic test_saturate();
    step(1, 0, '0, '0, '0, 0);
    for (int i = 0; i < 270; i++) step(0, 1, 4'(i), 16'(i), 16'(i + 1), 0);
    idle(0);
    checks++; if (obs_drops !== 8'd255) begin errors++; $display("FAIL sat_drops got %0d want 255", obs_drops); end
  endtask

  task automatic test_random();
    bit rst, req, rdy;
    logic [BW-1:0] b;
    logic [RW-1:0] lo, hi;
    step(1, 0, '0, '0, '0, 0);
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 2) != 0);
      b   = 4'($urandom_range(0, 1));
      lo  = 16'($urandom_range(0, 3));
      hi  = 16'($urandom_range(0, 3));
      step(rst, req, b, lo, hi, rdy);
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", c, obs_valid, exp_valid); end
      checks++; if (obs_row !== exp_row) begin errors++; $display("FAIL rnd_row cyc %0d got %h want %h", c, obs_row, exp_row); end
      checks++; if (obs_bank !== exp_bank) begin errors++; $display("FAIL rnd_bank cyc %0d got %h want %h", c, obs_bank, exp_bank); end
      checks++; if (obs_count !== exp_count) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, obs_count, exp_count); end
      checks++; if (obs_ovf !== exp_ovf) begin errors++; $display("FAIL rnd_ovf cyc %0d got %0b want %0b", c, obs_ovf, exp_ovf); end
      checks++; if (obs_drops !== exp_drops) begin errors++; $display("FAIL rnd_drops cyc %0d got %0d want %0d", c, obs_drops, exp_drops); end
    end
  endtask

  initial begin
    dif.req_i = 1'b0;
    dif.bank_id_i = '0;
    dif.victim_low_i = '0;
    dif.victim_high_i = '0;
    dif.pref_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_equal();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_dedup();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
